// File: rtl/gemm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gemm_pkg
//  Purpose  : Shared constants and types for the GEMM operand loader slice.
//             Tile geometry, tag width and default latency/credit depth.
//  Revision : 1.0  initial release
// ============================================================================
package gemm_pkg;

  localparam int ELEM_W          = 32;  // operand element width
  localparam int DIM             = 2;   // tile is DIM x DIM
  localparam int TILE_ELEMS      = 8;   // A then B elements per issued tile
  localparam int TAG_W           = 8;   // tile sequence number width
  localparam int LAT             = 6;   // default downstream GEMM latency
  localparam int MAX_OUT_DEFAULT = 6;   // default outstanding-tile limit

  localparam int TILE_W = DIM * DIM * ELEM_W;     // one packed operand tile
  localparam int BEAT_W = $clog2(TILE_ELEMS);     // beat counter width
  localparam int OUT_W  = 4;                      // holds 0..15 outstanding

  typedef logic [BEAT_W-1:0] beat_t;

  localparam beat_t BEAT_LAST = beat_t'(TILE_ELEMS - 1);

endpackage
`default_nettype wire

// File: rtl/gemm_valid_delay.sv
`default_nettype none
// ============================================================================
//  Module   : gemm_valid_delay
//  Purpose  : LAT-stage shift register carrying a valid flag and its tag.
//             out_valid/out_tag reproduce in_valid/in_tag exactly LAT cycles
//             later; a synchronous reset flushes every stage.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             in_valid, in_tag   - flag/tag entering the pipe
//             out_valid, out_tag - flag/tag leaving the pipe
//  Revision : 1.0  initial release
// ============================================================================
module gemm_valid_delay #(
  parameter int LAT   = 6,   // must be >= 1
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [LAT-1:0]   r_valid;
  logic [TAG_W-1:0] r_tag [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_tag[0]   <= in_tag;
      for (int s = 1; s < LAT; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_tag[s]   <= r_tag[s-1];
      end
    end
  end

  assign out_valid = r_valid[LAT-1];
  assign out_tag   = r_tag[LAT-1];

endmodule
`default_nettype wire

// File: rtl/gemm_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : gemm_operand_loader
//  Purpose  : Collects an 8-element stream (A00,A01,A10,A11,B00,B01,B10,B11)
//             into 2x2 A/B tiles, issues each tile with a one-cycle
//             tile_valid pulse and an 8-bit sequence tag, limits the number
//             of uncredited tiles, and predicts when the GEMM result appears.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             in_data/in_valid/in_ready - element stream handshake
//             a, b                  - packed tiles, elem [i][j] at 32*(2i+j)
//             tile_valid, tile_id   - issue pulse and its sequence number
//             res_credit            - consumer drained one result
//             res_valid, res_tag    - GEMM result flag and its tile_id
//             err_credit            - sticky: credit with nothing outstanding
//  Revision : 1.0  initial release
// ============================================================================
module gemm_operand_loader
  import gemm_pkg::*;
#(
  parameter int LAT     = gemm_pkg::LAT,
  parameter int MAX_OUT = MAX_OUT_DEFAULT   // 1..15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [TILE_W-1:0] a,
  output logic [TILE_W-1:0] b,
  output logic              tile_valid,
  output logic [TAG_W-1:0]  tile_id,
  input  logic              res_credit,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic              err_credit
);

  localparam logic [OUT_W-1:0] c_max_out = OUT_W'(MAX_OUT);
  localparam int               c_half    = DIM * DIM;   // elements per operand

  beat_t             r_beat;
  logic [ELEM_W-1:0] r_stage [TILE_ELEMS-1];
  logic [OUT_W-1:0]  r_outstanding;
  logic [TAG_W-1:0]  r_next_id;

  logic w_last;
  logic w_accept;
  logic w_issue;
  logic w_credit_ok;
  logic w_credit_err;

  // Only the completing beat is held back by the credit limit, so a tile can
  // be staged while the consumer catches up.
  assign w_last       = (r_beat == BEAT_LAST);
  assign in_ready     = !rst && (!w_last || (r_outstanding < c_max_out));
  assign w_accept     = in_valid && in_ready;
  assign w_issue      = w_accept && w_last;
  assign w_credit_ok  = res_credit && (r_outstanding != '0);
  assign w_credit_err = res_credit && (r_outstanding == '0);

  // Staging for beats 0..6. No reset needed: every entry is rewritten before
  // the next issue, and w_accept is low while rst is high.
  always_ff @(posedge clk) begin
    for (int k = 0; k < TILE_ELEMS - 1; k++) begin
      if (w_accept && (r_beat == beat_t'(k))) begin
        r_stage[k] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat        <= '0;
      a             <= '0;
      b             <= '0;
      tile_valid    <= 1'b0;
      tile_id       <= '0;
      r_next_id     <= '0;
      r_outstanding <= '0;
      err_credit    <= 1'b0;
    end else begin
      tile_valid <= w_issue;

      // Beat counter wraps 7 -> 0 on issue, so beat 0 of the next tile can be
      // accepted in the issue cycle.
      if (w_accept) begin
        r_beat <= r_beat + 1'b1;
      end

      // Beat 7 bypasses staging straight into the top B element.
      if (w_issue) begin
        for (int e = 0; e < c_half; e++) begin
          a[ELEM_W*e +: ELEM_W] <= r_stage[e];
          if (e == c_half - 1) begin
            b[ELEM_W*e +: ELEM_W] <= in_data;
          end else begin
            b[ELEM_W*e +: ELEM_W] <= r_stage[c_half + e];
          end
        end
        tile_id   <= r_next_id;
        r_next_id <= r_next_id + 1'b1;
      end

      // A credit with nothing outstanding is dropped (never underflows).
      if (w_issue && !w_credit_ok) begin
        r_outstanding <= r_outstanding + 1'b1;
      end else if (!w_issue && w_credit_ok) begin
        r_outstanding <= r_outstanding - 1'b1;
      end

      if (w_credit_err) begin
        err_credit <= 1'b1;
      end
    end
  end

  // tile_valid is registered, so LAT stages after it give result timing.
  gemm_valid_delay #(
    .LAT   (LAT),
    .TAG_W (TAG_W)
  ) u_res_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tile_valid),
    .in_tag    (tile_id),
    .out_valid (res_valid),
    .out_tag   (res_tag)
  );

endmodule
`default_nettype wire

// File: tb/tb_gemm_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gemm_operand_loader
//  Purpose  : Self-checking bench for gemm_operand_loader. Table vectors with
//             literal expected tiles, plus sequences for credit stall,
//             simultaneous issue/credit, credit underflow, mid-tile reset
//             and tag wrap. Issued tiles and predicted results are queued
//             and compared when the DUT presents them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gemm_operand_loader;

  localparam int LAT     = 6;
  localparam int MAX_OUT = 6;

  typedef logic [7:0][31:0] beats_t;   // beats[i] is element i of the stream

  typedef struct {
    beats_t       beats;
    logic [127:0] ea;
    logic [127:0] eb;
  } vec_t;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [7:0]   id;
    int           cyc;
  } tile_exp_t;

  typedef struct {
    logic [7:0] tag;
    int         cyc;
  } res_exp_t;

  logic         clk;
  logic         rst;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] a;
  logic [127:0] b;
  logic         tile_valid;
  logic [7:0]   tile_id;
  logic         res_credit;
  logic         res_valid;
  logic [7:0]   res_tag;
  logic         err_credit;

  gemm_operand_loader #(
    .LAT     (LAT),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .tile_valid (tile_valid),
    .tile_id    (tile_id),
    .res_credit (res_credit),
    .res_valid  (res_valid),
    .res_tag    (res_tag),
    .err_credit (err_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        n_tests = 0;
  int        n_fail  = 0;
  int        cyc     = 0;
  int        stalls  = 0;
  logic [7:0] exp_id = 8'd0;
  tile_exp_t tile_q[$];
  res_exp_t  res_q[$];
  vec_t      vecs[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge and checked
  // against the scoreboard queues.
  task automatic tick();
    tile_exp_t te;
    res_exp_t  re;
    @(posedge clk);
    #1;
    cyc++;
    while (tile_q.size() > 0 && tile_q[0].cyc < cyc) begin
      te = tile_q.pop_front();
      chk("tile_missing", 128'(cyc), 128'(te.cyc));
    end
    if (tile_valid === 1'b1) begin
      if (tile_q.size() == 0) begin
        chk("tile_unexpected", 128'(tile_valid), 128'(0));
      end else begin
        te = tile_q.pop_front();
        chk("tile_a", a, te.a);
        chk("tile_b", b, te.b);
        chk("tile_id", 128'(tile_id), 128'(te.id));
        chk("tile_cycle", 128'(cyc), 128'(te.cyc));
      end
    end
    while (res_q.size() > 0 && res_q[0].cyc < cyc) begin
      re = res_q.pop_front();
      chk("res_missing", 128'(cyc), 128'(re.cyc));
    end
    if (res_valid === 1'b1) begin
      if (res_q.size() == 0) begin
        chk("res_unexpected", 128'(res_valid), 128'(0));
      end else begin
        re = res_q.pop_front();
        chk("res_tag", 128'(res_tag), 128'(re.tag));
        chk("res_cycle", 128'(cyc), 128'(re.cyc));
      end
    end
  endtask

  // Present one element and wait (bounded) for it to be taken. For the last
  // beat, the tile and its result are queued before the accepting edge.
  task automatic beat(input logic [31:0] d, input bit last,
                      input logic [127:0] ea, input logic [127:0] eb);
    tile_exp_t te;
    res_exp_t  re;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 16) begin
      tick();
      n++;
      stalls++;
    end
    if (!in_ready) chk("beat_accept_timeout", 128'(in_ready), 128'(1));
    if (last) begin
      te.a = ea; te.b = eb; te.id = exp_id; te.cyc = cyc + 1;
      re.tag = exp_id; re.cyc = cyc + 1 + LAT;
      tile_q.push_back(te);
      res_q.push_back(re);
      exp_id = exp_id + 8'd1;
    end
    tick();
  endtask

  task automatic send_tile(input beats_t bt, input logic [127:0] ea,
                           input logic [127:0] eb, input int credit_beat);
    for (int i = 0; i < 8; i++) begin
      res_credit = (i == credit_beat);
      beat(bt[i], i == 7, ea, eb);
    end
    res_credit = 1'b0;
    in_valid   = 1'b0;
    in_data    = $urandom;
  endtask

  function automatic beats_t rand_beats();
    beats_t bt;
    for (int i = 0; i < 8; i++) bt[i] = $urandom;
    return bt;
  endfunction

  // A tile is A elements 0..3 then B elements 4..7, element 0 in the LSBs.
  task automatic send_rand(input int credit_beat);
    beats_t bt;
    bt = rand_beats();
    send_tile(bt, bt[3:0], bt[7:4], credit_beat);
  endtask

  task automatic send_partial(input beats_t bt, input int n);
    for (int i = 0; i < n; i++) beat(bt[i], 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    rst        = 1'b1;
    in_valid   = 1'b0;
    res_credit = 1'b0;
    tile_q.delete();
    res_q.delete();
    exp_id = 8'd0;
    repeat (n) tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beats_t bt;
    int c0;
    int s0;

    vecs[0].beats = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    vecs[0].ea    = 128'h00000004_00000003_00000002_00000001;
    vecs[0].eb    = 128'h00000008_00000007_00000006_00000005;
    vecs[1].beats = {8{32'hFFFFFFFF}};
    vecs[1].ea    = {4{32'hFFFFFFFF}};
    vecs[1].eb    = {4{32'hFFFFFFFF}};
    vecs[2].beats = {32'hF0F0F0F0, 32'h0F0F0F0F, 32'h5A5A5A5A, 32'hA5A5A5A5,
                     32'hCAFEF00D, 32'h12345678, 32'h00000000, 32'hDEADBEEF};
    vecs[2].ea    = 128'hCAFEF00D_12345678_00000000_DEADBEEF;
    vecs[2].eb    = 128'hF0F0F0F0_0F0F0F0F_5A5A5A5A_A5A5A5A5;
    vecs[3].beats = {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304,
                     32'hFFFFFFFE, 32'h7FFFFFFF, 32'h00000001, 32'h80000000};
    vecs[3].ea    = 128'hFFFFFFFE_7FFFFFFF_00000001_80000000;
    vecs[3].eb    = 128'h0D0E0F10_090A0B0C_05060708_01020304;

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; res_credit = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_a", a, 128'(0));
    chk("rst_b", b, 128'(0));
    chk("rst_tile_valid", 128'(tile_valid), 128'(0));
    chk("rst_tile_id", 128'(tile_id), 128'(0));
    chk("rst_res_valid", 128'(res_valid), 128'(0));
    chk("rst_res_tag", 128'(res_tag), 128'(0));
    chk("rst_err_credit", 128'(err_credit), 128'(0));
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 128'(in_ready), 128'(1));

    // Table vectors back-to-back, no credits: outstanding reaches 4
    for (int v = 0; v < 4; v++) send_tile(vecs[v].beats, vecs[v].ea, vecs[v].eb, -1);

    // Two more reach the limit of 6; the seventh stalls on its last beat
    send_rand(-1);
    send_rand(-1);
    bt = rand_beats();
    send_partial(bt, 7);
    in_valid = 1'b1; in_data = bt[7];
    chk("stall_ready_low", 128'(in_ready), 128'(0));
    repeat (3) tick();
    chk("stall_ready_held", 128'(in_ready), 128'(0));
    res_credit = 1'b1;
    tick();
    res_credit = 1'b0;
    chk("ready_after_credit", 128'(in_ready), 128'(1));
    beat(bt[7], 1'b1, bt[3:0], bt[7:4]);
    in_valid = 1'b0;

    // Outstanding 6 -> 3, then issue with a simultaneous credit keeps 3;
    // three more tiles must then fill exactly to the limit.
    res_credit = 1'b1;
    repeat (3) tick();
    res_credit = 1'b0;
    send_rand(7);
    repeat (3) send_rand(-1);
    bt = rand_beats();
    send_partial(bt, 7);
    in_valid = 1'b1; in_data = bt[7];
    chk("same_cycle_limit", 128'(in_ready), 128'(0));
    res_credit = 1'b1;
    tick();
    res_credit = 1'b0;
    beat(bt[7], 1'b1, bt[3:0], bt[7:4]);
    in_valid = 1'b0;
    repeat (LAT + 2) tick();

    // Credit with nothing outstanding: sticky error, counter stays at 0
    do_reset(2);
    res_credit = 1'b1;
    tick();
    res_credit = 1'b0;
    chk("err_set", 128'(err_credit), 128'(1));
    repeat (4) tick();
    chk("err_sticky", 128'(err_credit), 128'(1));
    repeat (MAX_OUT) send_rand(-1);
    bt = rand_beats();
    send_partial(bt, 7);
    in_valid = 1'b1; in_data = bt[7];
    chk("no_underflow_limit", 128'(in_ready), 128'(0));
    chk("err_still_set", 128'(err_credit), 128'(1));
    do_reset(2);
    chk("err_cleared", 128'(err_credit), 128'(0));

    // Mid-tile reset with a result in flight and a credit during reset
    send_rand(-1);
    bt = rand_beats();
    send_partial(bt, 5);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hBAD0BAD0; res_credit = 1'b1;
    tile_q.delete(); res_q.delete(); exp_id = 8'd0;
    tick();
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    chk("midrst_a", a, 128'(0));
    chk("midrst_b", b, 128'(0));
    chk("midrst_tile_id", 128'(tile_id), 128'(0));
    chk("midrst_res_valid", 128'(res_valid), 128'(0));
    rst = 1'b0; res_credit = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_err", 128'(err_credit), 128'(0));
    send_tile(vecs[2].beats, vecs[2].ea, vecs[2].eb, -1);

    // 257 tiles with one credit per tile: tag wrap, no stalls, 8 cycles/tile
    s0 = stalls;
    c0 = cyc;
    for (int t = 0; t < 257; t++) send_rand(0);
    chk("wrap_no_stalls", 128'(stalls), 128'(s0));
    chk("wrap_cycles", 128'(cyc - c0), 128'(257 * 8));
    chk("wrap_err", 128'(err_credit), 128'(0));

    repeat (LAT + 3) tick();
    chk("tile_q_drained", 128'(tile_q.size()), 128'(0));
    chk("res_q_drained", 128'(res_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
